of_stage_p: RTL
===============

OF_STAGE_P -- requirements
Module: of_stage_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath, PC and register width; legal range 32..64.
REQ-002 SHALL have parameter CTRL_W, default 24, control bus width; minimum 21.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instruction_in/pc_in/control_bus_in are valid.
REQ-006 SHALL have port instruction_in  input  32  fetched instruction.
REQ-007 SHALL have port pc_in  input  DATA_W  PC of instruction_in.
REQ-008 SHALL have port control_bus_in  input  CTRL_W  decoded controls: [13] is_ld, [14] is_st, [19] is_ret, [20] is_imm.
REQ-009 SHALL have port is_wb  input  1  write-back enable.
REQ-010 SHALL have port wr_adr  input  4  write-back register index.
REQ-011 SHALL have port wr_data  input  DATA_W  write-back data.
REQ-012 SHALL have port flush  input  1  squash the instruction being loaded into OF/EX.
REQ-013 SHALL have port hold  input  1  downstream stall; freeze OF/EX.
REQ-014 SHALL have port stall_out  output  1  upstream must re-present the same instruction next cycle.
REQ-015 SHALL have ports out_valid (1), pc_out (DATA_W), instruction_out (32), control_bus_out (CTRL_W), btarget_out, A_out, B_out, op2_out (DATA_W each), all outputs of the OF/EX register.

Function
REQ-016 SHALL contain 16 x DATA_W registers; write on the rising edge when is_wb=1; no reads or writes are suppressed for r0.
REQ-017 SHALL read A from index 15 if is_ret, else instruction_in[21:18].
REQ-018 SHALL read op2 from instruction_in[25:22] if is_st, else instruction_in[17:14].
REQ-019 SHALL set immediate to instruction_in[17:0] sign-extended to DATA_W; B = is_imm ? immediate : op2.
REQ-020 SHALL set btarget to pc_in + (sign-extended instruction_in[26:0] << 2), truncated modulo 2^DATA_W.
REQ-021 SHALL detect hazard = in_valid & out_valid & control_bus_out[13] & (instruction_out[25:22] == A index, or == op2 index when is_imm=0 or is_st=1).
REQ-022 SHALL drive stall_out = (hazard | hold) & ~flush, combinationally.
REQ-023 SHALL give the OF/EX update priority per edge as: flush, then hold, then hazard, then load.
REQ-024 flush SHALL load a bubble: out_valid=0, control_bus_out=0, other fields 0.
REQ-025 hold (no flush) SHALL keep every OF/EX output unchanged.
REQ-026 hazard (no flush, no hold) SHALL load a bubble; the next cycle SHALL load normally if the hazard has cleared (single-cycle load-use stall).
REQ-027 load SHALL capture all computed fields, with out_valid=in_valid; when in_valid=0, control_bus_out SHALL be 0.
REQ-028 SHALL give latency of 1 cycle from an accepted instruction to the OF/EX outputs.

Reset
REQ-029 reset=0 SHALL asynchronously clear all 16 registers and all OF/EX outputs to 0, out_valid=0.
REQ-030 A write-back coincident with reset SHALL be discarded; the first legal write is on the first rising edge after reset deasserts.

Configuration
REQ-031 With OF_WB_BYPASS_EN defined: a read whose index equals wr_adr while is_wb=1 SHALL return wr_data in the same cycle (write-through).
REQ-032 Without OF_WB_BYPASS_EN: reads SHALL return the pre-edge register contents; the new value is visible from the next cycle.

Verification
REQ-033 Write r3=0x1234 then issue add using r3 -> A_out=0x1234 one cycle after issue.
REQ-034 Same-cycle write r5=0xAA and read r5 -> A_out=0xAA with the macro, old value (0) without it.
REQ-035 ld r2 followed by add r4,r2,r1 -> stall_out=1 for one cycle, one bubble (out_valid=0), then add with the correct operands.
REQ-036 hold=1 for 3 cycles with flush=1 asserted in cycle 2 -> outputs frozen in cycle 1, bubble after the cycle-2 edge, stall_out=0 in cycle 2.
REQ-037 pc_in=0x100, offset field=0x7FFFFFF (i.e. -1) -> btarget_out=0xFC; imm field=0x20000 -> B_out sign-extended to 0xFFFE0000.
REQ-038 Assert reset mid-stream with a pending stall -> all outputs 0 and stall_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/of_stage_p.sv
// Operand-fetch stage: 16-entry register file, operand/immediate/branch-target
// formation, load-use hazard detection and the OF/EX pipeline register.
// Optional write-through of the write-back port is enabled by defining OF_WB_BYPASS_EN.
module of_stage_p #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instruction_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [CTRL_W-1:0] control_bus_in,
    input  logic              is_wb,
    input  logic [3:0]        wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              hold,
    output logic              stall_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] pc_out,
    output logic [31:0]       instruction_out,
    output logic [CTRL_W-1:0] control_bus_out,
    output logic [DATA_W-1:0] btarget_out,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic [DATA_W-1:0] op2_out
);

    logic [DATA_W-1:0] rf [16];

    logic              is_ld_q;
    logic              is_st;
    logic              is_ret;
    logic              is_imm;
    logic [3:0]        a_idx;
    logic [3:0]        op2_idx;
    logic [3:0]        ld_dest;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] op2_val;
    logic [DATA_W-1:0] immediate;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] btarget;
    logic [DATA_W-1:0] b_val;
    logic              hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                rf[i] <= '0;
            end
        end else if (is_wb) begin
            rf[wr_adr] <= wr_data;
        end
    end

    assign is_st   = control_bus_in[14];
    assign is_ret  = control_bus_in[19];
    assign is_imm  = control_bus_in[20];
    assign is_ld_q = control_bus_out[13];
    assign ld_dest = instruction_out[25:22];

    assign a_idx   = is_ret ? 4'd15 : instruction_in[21:18];
    assign op2_idx = is_st ? instruction_in[25:22] : instruction_in[17:14];

`ifdef OF_WB_BYPASS_EN
    assign a_val   = (is_wb && (wr_adr == a_idx))   ? wr_data : rf[a_idx];
    assign op2_val = (is_wb && (wr_adr == op2_idx)) ? wr_data : rf[op2_idx];
`else
    assign a_val   = rf[a_idx];
    assign op2_val = rf[op2_idx];
`endif

    assign immediate = {{(DATA_W-18){instruction_in[17]}}, instruction_in[17:0]};
    assign offset    = {{(DATA_W-27){instruction_in[26]}}, instruction_in[26:0]};
    assign btarget   = pc_in + (offset << 2);
    assign b_val     = is_imm ? immediate : op2_val;

    // op2 only matters as a source when it is not replaced by the immediate, or for stores
    assign hazard = in_valid & out_valid & is_ld_q &
                    ((ld_dest == a_idx) | ((~is_imm | is_st) & (ld_dest == op2_idx)));

    // Gated by reset so a pending stall drops the moment reset asserts
    assign stall_out = reset & (hazard | hold) & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid       <= 1'b0;
            pc_out          <= '0;
            instruction_out <= '0;
            control_bus_out <= '0;
            btarget_out     <= '0;
            A_out           <= '0;
            B_out           <= '0;
            op2_out         <= '0;
        end else if (flush || (!hold && hazard)) begin
            out_valid       <= 1'b0;
            pc_out          <= '0;
            instruction_out <= '0;
            control_bus_out <= '0;
            btarget_out     <= '0;
            A_out           <= '0;
            B_out           <= '0;
            op2_out         <= '0;
        end else if (!hold) begin
            out_valid       <= in_valid;
            pc_out          <= pc_in;
            instruction_out <= instruction_in;
            control_bus_out <= in_valid ? control_bus_in : '0;
            btarget_out     <= btarget;
            A_out           <= a_val;
            B_out           <= b_val;
            op2_out         <= op2_val;
        end
    end

endmodule
